// File: rtl/conv1_sched.sv
// conv1 layer sequencer: per output map, loads the 5x5 kernel, clears and runs the
// address generator for one 24x24 map, and emits latency-aligned MAC and output strobes.
module conv1_sched #(
    parameter int N_MAPS       = 6,
    parameter int RD_LAT       = 1,
    parameter int TAPS         = 25,
    parameter int PIX_PER_LANE = 144
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [9:0] w_addr,
    output logic       w_load,
    output logic [4:0] w_idx,
    output logic       agen_rst,
    output logic       agen_en,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       out_we,
    output logic [7:0] out_pix,
    output logic [4:0] map_idx
);
    typedef enum logic [2:0] {IDLE, WLOAD, WDRAIN, ARST, RUN, DRAIN, NEXT, DONE} state_t;

    localparam logic [4:0] TAP_LAST = 5'(TAPS - 1);
    localparam logic [7:0] PIX_LAST = 8'(PIX_PER_LANE - 1);

    state_t     state;
    logic [4:0] k;
    logic [4:0] tap;
    logic [7:0] pix;
    logic [2:0] cnt;
    logic       w_rd;

    // Delay pipes matching the memory read latency.
    logic [RD_LAT-1:0]      wv_pipe;
    logic [RD_LAT-1:0][4:0] wi_pipe;
    logic [RD_LAT-1:0]      vld_pipe;
    logic [RD_LAT-1:0]      clr_pipe;
    logic [RD_LAT-1:0]      last_pipe;
    logic [RD_LAT-1:0][7:0] pix_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_addr   <= '0;
            w_rd     <= 1'b0;
            k        <= '0;
            tap      <= '0;
            pix      <= '0;
            cnt      <= '0;
            agen_rst <= 1'b0;
            agen_en  <= 1'b0;
            map_idx  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= WLOAD;
                        map_idx <= '0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        k       <= '0;
                        w_addr  <= '0;
                        w_rd    <= 1'b1;
                    end
                end
                WLOAD: begin
                    if (k == TAP_LAST) begin
                        state <= WDRAIN;
                        w_rd  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        k      <= k + 5'd1;
                        w_addr <= w_addr + 10'd1;
                    end
                end
                WDRAIN: begin
                    if (cnt == 3'(RD_LAT - 1)) begin
                        state    <= ARST;
                        agen_rst <= 1'b1;
                        tap      <= '0;
                        pix      <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ARST: begin
                    state    <= RUN;
                    agen_rst <= 1'b0;
                    agen_en  <= 1'b1;
                end
                RUN: begin
                    if (tap == TAP_LAST) begin
                        tap <= '0;
                        if (pix == PIX_LAST) begin
                            state   <= DRAIN;
                            agen_en <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            pix <= pix + 8'd1;
                        end
                    end else begin
                        tap <= tap + 5'd1;
                    end
                end
                DRAIN: begin
                    // One extra cycle lets the final registered out_we retire.
                    if (cnt == 3'(RD_LAT)) state <= NEXT;
                    else                   cnt   <= cnt + 3'd1;
                end
                NEXT: begin
                    if (map_idx == 5'(N_MAPS - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        map_idx <= map_idx + 5'd1;
                        state   <= WLOAD;
                        k       <= '0;
                        w_addr  <= (10'(map_idx) + 10'd1) * 10'(TAPS);
                        w_rd    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wv_pipe   <= '0;
            wi_pipe   <= '0;
            vld_pipe  <= '0;
            clr_pipe  <= '0;
            last_pipe <= '0;
            pix_pipe  <= '0;
            out_we    <= 1'b0;
            out_pix   <= '0;
        end else begin
            wv_pipe[0]   <= w_rd;
            wi_pipe[0]   <= k;
            vld_pipe[0]  <= agen_en;
            clr_pipe[0]  <= agen_en && (tap == 5'd0);
            last_pipe[0] <= agen_en && (tap == TAP_LAST);
            pix_pipe[0]  <= pix;
            for (int i = 1; i < RD_LAT; i++) begin
                wv_pipe[i]   <= wv_pipe[i-1];
                wi_pipe[i]   <= wi_pipe[i-1];
                vld_pipe[i]  <= vld_pipe[i-1];
                clr_pipe[i]  <= clr_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                pix_pipe[i]  <= pix_pipe[i-1];
            end
            out_we <= last_pipe[RD_LAT-1];
            if (last_pipe[RD_LAT-1]) out_pix <= pix_pipe[RD_LAT-1];
        end
    end

    assign w_load  = wv_pipe[RD_LAT-1];
    assign w_idx   = wi_pipe[RD_LAT-1];
    assign mac_en  = vld_pipe[RD_LAT-1];
    assign mac_clr = clr_pipe[RD_LAT-1];
endmodule

// File: doc/conv1_sched.md
Name: conv1_sched

Overview:
Top-level sequencer for the conv1 layer. For each output feature map it:
- fetches that map's 5x5 kernel from weight memory,
- clears and runs the four-lane input-image address generator for one full 24x24 output map,
- drives the MAC array's clear/accumulate strobes, aligned to memory read latency,
- issues the output-memory write strobe.

It sits between the host start/done handshake and the address generator, weight memory, MAC lanes and output memory.

Parameters:
N_MAPS, 6, number of conv1 output maps (1..32)
RD_LAT, 1, read latency of weight and image memories in cycles (1..4)
TAPS, 25, kernel taps per output pixel (fixed 5x5)
PIX_PER_LANE, 144, output pixels per lane per map (24*24/4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin layer; sampled only in IDLE or DONE
busy  out  1  high from the cycle after accepted start until DONE is entered
done  out  1  high while in DONE; cleared by an accepted start or by reset
w_addr  out  10  weight memory read address = map_idx*25 + k
w_load  out  1  kernel register write strobe, RD_LAT cycles after the matching w_addr
w_idx  out  5  kernel register index (0..24) accompanying w_load
agen_rst  out  1  one-cycle clear pulse to the address generator
agen_en  out  1  address generator advance enable
mac_clr  out  1  MAC loads the product instead of accumulating (tap 0 data valid)
mac_en  out  1  MAC operand valid (image data for the current tap is on the bus)
out_we  out  1  write all four lane sums to output memory
out_pix  out  8  pixel index within lane (0..143) for out_we
map_idx  out  5  current output map index

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and delay pipes 0.
- States: IDLE, WLOAD, WDRAIN, ARST, RUN, DRAIN, NEXT, DONE.
- IDLE/DONE + start=1: map_idx<=0, done<=0, go to WLOAD.
- WLOAD, 25 cycles: w_addr = map_idx*25 + k, k counts 0..24; then go to WDRAIN.
- w_load/w_idx: k and valid delayed through an RD_LAT-deep pipe.
- WDRAIN: RD_LAT cycles, no new weight reads; then go to ARST.
- ARST: agen_rst=1 for exactly 1 cycle; tap and pix counters cleared; then go to RUN.
- RUN: agen_en=1 for exactly TAPS*PIX_PER_LANE = 3600 consecutive cycles.
  - tap counts 0..24 and wraps; pix increments on the tap wrap.
  - Exit to DRAIN after tap=24 with pix=143.
- Issue pipe: (valid=agen_en, tap, pix) delayed RD_LAT cycles.
  - mac_en = delayed valid.
  - mac_clr = delayed valid AND delayed tap==0.
- Write strobe: out_we registered one cycle after (delayed valid AND delayed tap==24); out_pix = that delayed pix, registered.
  - First out_we occurs RUN-entry + 25 + RD_LAT cycles.
  - Exactly 144 out_we per map, out_pix strictly 0..143 in order.
- DRAIN: RD_LAT+1 cycles, letting the last mac_en and out_we retire; then go to NEXT.
- NEXT, 1 cycle: if map_idx==N_MAPS-1, go to DONE; else map_idx+1 and go to WLOAD.
- busy=1 in every state except IDLE and DONE.
- Map period = 3628 + 2*RD_LAT cycles (3630 at RD_LAT=1).
  - Layer latency from start to done = N_MAPS*map period + 1.
- start while busy: ignored, with no effect on any counter.
- DONE + start: restart, map_idx<=0.
- Width rules: w_addr computed in 10 bits, with no wrap for N_MAPS<=32 (max 799). pix is 8 bits and never exceeds 143.
- Mutual exclusion: w_load and mac_en never high in the same cycle. agen_en and agen_rst never high together.
- Reset mid-operation: immediate return to IDLE; all strobes drop asynchronously; no further out_we.

Test Plan:
1. N_MAPS=1, RD_LAT=1, single start pulse -> busy high 3630 cycles; done rises at start+3631; exactly 25 w_load, 1 agen_rst, 3600 agen_en, 3600 mac_en, 144 mac_clr, 144 out_we.
2. Alignment check -> every mac_clr coincides with mac_en; out_we follows every 25th mac_en by 1 cycle; out_pix sequence 0,1,...,143; first out_we at RUN entry + 26.
3. N_MAPS=6 -> w_addr ranges 0..24, 25..49, ..., 125..149; map_idx steps 0..5; done after 6*3630+1 cycles; 864 total out_we.
4. start pulsed repeatedly during RUN -> no change in counts, map_idx or timing versus scenario 1; start in DONE restarts with map_idx=0 and done cleared next cycle.
5. reset asserted mid-RUN (map 2, pix 70) -> all outputs 0 same cycle; IDLE after release; subsequent start gives a full clean run from map 0.
6. RD_LAT=3 -> w_load lags w_addr by 3 cycles; mac_en lags agen_en by 3; map period 3634; still 144 out_we per map.
